// File: rtl/stack_arbiter_pkg.sv
// Shared types and op encodings for the stack arbiter and its requesters.
package stack_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_arbiter_if.sv
// Request/response bundle between the requesting engines and the stack arbiter.
interface stack_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1, pointer moves only on an enabled grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c,
  output logic                       grant_valid_c
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] last_q;
  logic [IDW-1:0] cand;

  // First requester found walking upward from the one after the last winner
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = '0;
    if (enable) begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = IDW'((32'(last_q) + i) % NUM_REQ);
        if (!grant_valid_c && req[cand]) begin
          grant_valid_c = 1'b1;
          grant_idx_c   = cand;
        end
      end
    end
    if (grant_valid_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)              last_q <= IDW'(NUM_REQ - 1);
    else if (grant_valid_c) last_q <= grant_idx_c;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between NUM_REQ requesters; one tagged op at a time, full/empty
// rejected locally from a private occupancy count.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  stack_arbiter_if.slave               bus,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [DATA_WIDTH-1:0]        stk_wdata,
  input  logic [DATA_WIDTH-1:0]        stk_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         busy
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned OCW  = $clog2(DEPTH + 1);
  localparam int unsigned CNTW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  op_q, op_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [OCW-1:0]        occ_q, occ_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    grant_c;
  logic [IDW-1:0]        grant_idx_c;
  logic                  grant_valid_c;
  logic                  sel_op;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  reject;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock         (clock),
    .reset         (reset),
    .req           (bus.req_valid),
    .enable        (state_q == IDLE),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    id_d        = id_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    occ_d       = occ_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    sel_op      = OP_PUSH;
    sel_data    = '0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_op   = bus.req_op[i];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    reject = (sel_op == OP_PUSH) ? (occ_q == OCW'(DEPTH)) : (occ_q == '0);

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          id_d    = grant_idx_c;
          op_d    = sel_op;
          err_d   = reject;
          rdata_d = '0;
          if (reject) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            wdata_d = sel_data;
            state_d = ISSUE;
            push_d  = (sel_op == OP_PUSH);
            pop_d   = (sel_op == OP_POP);
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_PUSH) begin
          occ_d       = occ_q + 1'b1;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          occ_d   = occ_q - 1'b1;
          cnt_d   = CNTW'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d     = stk_rdata;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_PUSH;
      id_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      occ_q       <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      occ_q       <= occ_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Grant is the only combinational output: it must pulse in the arbitration cycle
  assign bus.req_ready = grant_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = err_q;
  assign stk_push      = push_q;
  assign stk_pop       = pop_q;
  assign stk_wdata     = wdata_q;
  assign occupancy     = occ_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter (DEPTH=4, RD_LATENCY=2) against a small LIFO stack model.
module tb_stack_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned RD_LATENCY = 2;

  logic        clock;
  logic        reset;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_wdata;
  logic [31:0] stk_rdata;
  logic [2:0]  occupancy;
  logic        busy;

  int n_cmp;
  int n_err;

  stack_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  stack_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .occupancy (occupancy),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // LIFO stack model with a two-stage read pipeline, sharing the arbiter's reset
  logic [31:0] mem [0:7];
  logic [3:0]  sp;
  logic [31:0] pipe0, pipe1;
  assign stk_rdata = pipe1;

  always @(posedge clock) begin
    if (reset) begin
      sp    <= '0;
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      pipe1 <= pipe0;
      if (stk_push) begin
        mem[sp[2:0]] <= stk_wdata;
        sp           <= sp + 4'd1;
      end else if (stk_pop) begin
        pipe0 <= mem[sp[2:0] - 3'd1];
        sp    <= sp - 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_data = '0; bus.rsp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    n_cmp++; if (bus.rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_cmp++; if ({stk_push, stk_pop} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {stk_push, stk_pop}); end
    n_cmp++; if (stk_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", stk_wdata); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
  endtask

  // Requester 1 pushes then pops the same word back
  task automatic test_push_pop();
    bus.req_valid = 4'b0010; bus.req_op = 4'b0000; bus.req_data[63:32] = 32'hA5A5_0001;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL push_grant: got %b want 0010", bus.req_ready); end
    tick(); bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if ({stk_push, stk_pop} !== 2'b10) begin n_err++; $display("FAIL push_strobe: got %b want 10", {stk_push, stk_pop}); end
    n_cmp++; if (stk_wdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL push_wdata: got %h want a5a50001", stk_wdata); end
    tick(); @(negedge clock);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd1) begin
      n_err++; $display("FAIL push_rsp: got v=%b e=%b id=%0d want v=1 e=0 id=1", bus.rsp_valid, bus.rsp_err, bus.rsp_id); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL push_occ: got %0d want 1", occupancy); end
    tick();
    bus.req_valid = 4'b0010; bus.req_op = 4'b0010;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL pop_grant: got %b want 0010", bus.req_ready); end
    tick(); bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if ({stk_push, stk_pop} !== 2'b01) begin n_err++; $display("FAIL pop_strobe: got %b want 01", {stk_push, stk_pop}); end
    for (int c = 2; c <= 3; c++) begin
      tick(); @(negedge clock);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL pop_early_rsp T+%0d: got %b want 0", c, bus.rsp_valid); end
    end
    tick(); @(negedge clock);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hA5A5_0001 || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL pop_rsp: got v=%b d=%h id=%0d e=%b want v=1 d=a5a50001 id=1 e=0",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL pop_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_pop_empty();
    bus.req_valid = 4'b1000; bus.req_op = 4'b1000;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL empty_grant: got %b want 1000", bus.req_ready); end
    tick(); bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd3) begin
      n_err++; $display("FAIL empty_rsp: got v=%b e=%b d=%h id=%0d want v=1 e=1 d=0 id=3",
                        bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_id); end
    n_cmp++; if (stk_pop !== 1'b0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL empty_side_effect: got pop=%b occ=%0d want pop=0 occ=0", stk_pop, occupancy); end
    tick();
  endtask

  // All four push continuously; fifth grant (requester 0 again) hits full
  task automatic test_round_robin();
    logic [3:0] exp_g;
    bit found;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    bus.req_valid = 4'b1111; bus.req_op = 4'b0000;
    bus.req_data = {32'h103, 32'h102, 32'h101, 32'h100};
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      found = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clock);
        if (bus.req_ready !== 4'b0000) begin found = 1'b1; break; end
      end
      if (!found) begin
        n_cmp++; n_err++; $display("FAIL rr_timeout grant %0d: got none want %b", k, exp_g);
      end else begin
        n_cmp++; if (bus.req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant %0d: got %b want %b", k, bus.req_ready, exp_g); end
        n_cmp++; if (occupancy !== 3'(k)) begin n_err++; $display("FAIL rr_occ %0d: got %0d want %0d", k, occupancy, k); end
        @(negedge clock);
        if (k < 4) begin
          n_cmp++; if (stk_push !== 1'b1 || stk_wdata !== 32'h100 + 32'(k)) begin
            n_err++; $display("FAIL rr_push %0d: got push=%b d=%h want push=1 d=%h", k, stk_push, stk_wdata, 32'h100 + 32'(k)); end
        end else begin
          n_cmp++; if (stk_push !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin
            n_err++; $display("FAIL full_reject: got push=%b v=%b e=%b want push=0 v=1 e=1", stk_push, bus.rsp_valid, bus.rsp_err); end
        end
      end
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if (occupancy !== 3'd4 || busy !== 1'b0) begin
      n_err++; $display("FAIL full_occ: got occ=%0d busy=%b want occ=4 busy=0", occupancy, busy); end
    tick();
  endtask

  // Requester 2 pops with rsp_ready held low; requester 0 waits with a push
  task automatic test_rsp_hold();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100; bus.req_op = 4'b0100;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL hold_grant: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001; bus.req_op = 4'b0000; bus.req_data[31:0] = 32'h200;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL hold_busy_grant T+%0d: got %b want 0000", c, bus.req_ready); end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h103 || bus.rsp_id !== 2'd2 || bus.req_ready !== 4'b0000) begin
        n_err++; $display("FAIL hold_stable %0d: got v=%b d=%h id=%0d rdy=%b want v=1 d=103 id=2 rdy=0000",
                          c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); end
    end
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL hold_release: got v=%b rdy=%b want v=1 rdy=0000", bus.rsp_valid, bus.req_ready); end
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_next_grant: got rdy=%b v=%b want rdy=0001 v=0", bus.req_ready, bus.rsp_valid); end
    tick(); bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if (stk_push !== 1'b1 || stk_wdata !== 32'h200) begin
      n_err++; $display("FAIL hold_push: got push=%b d=%h want push=1 d=200", stk_push, stk_wdata); end
    @(negedge clock);
    n_cmp++; if (occupancy !== 3'd4 || bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL hold_occ: got occ=%0d e=%b want occ=4 e=0", occupancy, bus.rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.req_valid = 4'b0010; bus.req_op = 4'b0010;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_grant: got %b want 0010", bus.req_ready); end
    tick(); bus.req_valid = '0;
    @(negedge clock);
    n_cmp++; if (stk_pop !== 1'b1) begin n_err++; $display("FAIL rst_pop_strobe: got %b want 1", stk_pop); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_state: got busy=%b v=%b want busy=1 v=0", busy, bus.rsp_valid); end
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL rst_after: got busy=%b v=%b occ=%0d want busy=0 v=0 occ=0", busy, bus.rsp_valid, occupancy); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale %0d: got %b want 0", c, bus.rsp_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_push_pop();
    test_pop_empty();
    test_round_robin();
    test_rsp_hold();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
